// File: rtl/add_accum_stage_pkg.sv
// Shared types and default sizing for the accumulate stage.
package add_pkg;

    localparam int unsigned DEFAULT_WIDTH = 4;
    localparam int unsigned DEFAULT_CNTW  = 4;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        DONE
    } state_t;

endpackage

// File: rtl/add_accum_stage_rca.sv
// Ripple-carry adder built from a chain of full-adder cells; c_out is the MSB carry.
module rca_n #(
    parameter int unsigned WIDTH = 4
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic [WIDTH-1:0] s,
    output logic             c_out
);

    logic carry;

    always_comb begin
        carry = c_in;
        s     = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            s[i]  = a[i] ^ b[i] ^ carry;
            carry = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
        end
        c_out = carry;
    end

endmodule

// File: rtl/add_accum_stage.sv
// Counted-operand accumulator with valid/ready handshakes on both sides.
// Define SATURATE_EN to clamp the accumulator to all-ones once a carry-out occurs.
module add_accum_stage
    import add_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH,
    parameter int unsigned CNTW  = DEFAULT_CNTW
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [CNTW-1:0]  count,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_ovf,
    output logic             busy
);

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  acc_q, acc_d;
    logic [CNTW-1:0]   rem_q, rem_d;
    logic              ovf_q, ovf_d;

    logic [WIDTH-1:0]  add_s;
    logic              add_c;

    rca_n #(.WIDTH(WIDTH)) u_rca (
        .a     (acc_q),
        .b     (in_data),
        .c_in  (1'b0),
        .s     (add_s),
        .c_out (add_c)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            acc_q   <= '0;
            rem_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            rem_q   <= rem_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        rem_d   = rem_q;
        ovf_d   = ovf_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    acc_d   = '0;
                    ovf_d   = 1'b0;
                    rem_d   = count;
                    state_d = (count != '0) ? ACCUM : DONE;
                end
            end
            ACCUM: begin
                // in_ready is 1 throughout ACCUM, so in_valid alone marks a transfer
                if (in_valid) begin
                    acc_d = add_s;
                    ovf_d = ovf_q | add_c;
`ifdef SATURATE_EN
                    if (add_c || ovf_q) begin
                        acc_d = '1;
                    end
`endif
                    rem_d = rem_q - CNTW'(1);
                    if (rem_q == CNTW'(1)) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign in_ready  = (state_q == ACCUM);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign out_sum   = out_valid ? acc_q : '0;
    assign out_ovf   = out_valid & ovf_q;

endmodule
